// File: rtl/payload_engine_sched.sv
// Per-packet sequencer for a bank of regex match engines: clear, step, drain, report.
// Optional statistics counters are built when PAYLOAD_SCHED_STATS_EN is defined.
module payload_engine_sched #(
  parameter int NUM_ENG   = 64,
  parameter int MAX_BYTES = 1500,
  parameter int DRAIN_CYC = 2,
  parameter int CNT_W     = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  output logic [7:0]         dec_byte,
  output logic               dec_kill,
  output logic               sod,
  output logic               en,
  input  logic [NUM_ENG-1:0] eng_match,
  output logic [NUM_ENG-1:0] res_vec,
  output logic               res_trunc,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2:0]         state_dbg
`ifdef PAYLOAD_SCHED_STATS_EN
  ,
  output logic [31:0]        stat_pkts,
  output logic [31:0]        stat_hits,
  output logic [31:0]        stat_trunc
`endif
);

  localparam int DRAIN_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

  // Handshakes: s_data is taken on a cycle with s_valid & s_ready; the result
  // is taken on res_valid & res_ready and holds stable until then.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    REPORT = 3'd4
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   byte_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               trunc;

  assign s_ready   = (state == RUN);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      drain_cnt <= '0;
      trunc     <= 1'b0;
      sod       <= 1'b0;
      en        <= 1'b0;
      dec_kill  <= 1'b0;
      dec_byte  <= 8'd0;
      res_valid <= 1'b0;
      res_vec   <= '0;
      res_trunc <= 1'b0;
    end else begin
      sod      <= 1'b0;
      en       <= 1'b0;
      dec_kill <= 1'b0;
      case (state)
        IDLE: begin
          // The first byte only wakes us up; it is consumed later in RUN.
          if (s_valid) begin
            state <= CLEAR;
            sod   <= 1'b1;
          end
        end
        CLEAR: state <= RUN;
        RUN: begin
          if (s_valid) begin
            if (byte_cnt < CNT_W'(MAX_BYTES)) begin
              en       <= 1'b1;
              dec_byte <= s_data;
              byte_cnt <= byte_cnt + 1'b1;
            end else begin
              trunc <= 1'b1;
            end
            if (s_last) begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_W'(DRAIN_CYC);
            end
          end
        end
        DRAIN: begin
          // Null steps push the last byte through decode and into the end state.
          if (drain_cnt != '0) begin
            en        <= 1'b1;
            dec_kill  <= 1'b1;
            dec_byte  <= 8'd0;
            drain_cnt <= drain_cnt - 1'b1;
          end else begin
            state     <= REPORT;
            res_valid <= 1'b1;
            res_vec   <= eng_match;
            res_trunc <= trunc;
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            byte_cnt  <= '0;
            trunc     <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PAYLOAD_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pkts  <= 32'd0;
      stat_hits  <= 32'd0;
      stat_trunc <= 32'd0;
    end else if (state == REPORT && res_valid && res_ready) begin
      stat_pkts <= stat_pkts + 32'd1;
      if (|res_vec) stat_hits <= stat_hits + 32'd1;
      if (res_trunc) stat_trunc <= stat_trunc + 32'd1;
    end
  end
`endif

endmodule
